switch_forwarder: RTL

//  Crossbar forwarding stage of the 4x4 packet switcher. Holds one packet per input port and

---
 rtl/switch_forwarder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/switch_forwarder.sv
// Crossbar forwarding stage of a 4x4 packet switch: one holding register per input,
// fast-path forwarding for uncontested packets, round-robin arbitration per output.
module switch_forwarder #(
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        in_valid,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    input  logic [1:0]        in_dest0,
    input  logic [1:0]        in_dest1,
    input  logic [1:0]        in_dest2,
    input  logic [1:0]        in_dest3,
    output logic [3:0]        in_ready,
    output logic [1:0]        dest0,
    output logic [1:0]        dest1,
    output logic [1:0]        dest2,
    output logic [1:0]        dest3,
    input  logic [3:0]        valid_bit,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [3:0]        stall_flag
);
    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(WAIT_MAX);

    logic [DATA_W-1:0] in_data_a [4];
    logic [1:0]        in_dest_a [4];

    logic [3:0]        full_q, full_d;
    logic [3:0]        settled_q, settled_d;
    logic [DATA_W-1:0] data_q [4];
    logic [DATA_W-1:0] data_d [4];
    logic [1:0]        dest_q [4];
    logic [1:0]        dest_d [4];
    logic [WAIT_W-1:0] wait_q [4];
    logic [WAIT_W-1:0] wait_d [4];
    logic [1:0]        rr_q [4];
    logic [1:0]        rr_d [4];
    logic [3:0]        out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q [4];
    logic [DATA_W-1:0] out_data_d [4];

    logic [3:0] fast;
    logic [3:0] grant;
    logic [3:0] load;
    logic [3:0] g_valid;
    logic [3:0] g_arb;
    logic [1:0] g_win [4];

    assign in_data_a[0] = in_data0;
    assign in_data_a[1] = in_data1;
    assign in_data_a[2] = in_data2;
    assign in_data_a[3] = in_data3;
    assign in_dest_a[0] = in_dest0;
    assign in_dest_a[1] = in_dest1;
    assign in_dest_a[2] = in_dest2;
    assign in_dest_a[3] = in_dest3;

    // A ValidBit only means something once the checker has seen this packet's dest.
    assign fast = settled_q & valid_bit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_out
            logic       found;
            logic       by_arb;
            logic [1:0] win;
            logic [1:0] idx;

            always_comb begin
                found  = 1'b0;
                by_arb = 1'b0;
                win    = 2'd0;
                idx    = 2'd0;
                for (int i = 0; i < 4; i++) begin
                    if (!found && fast[i] && dest_q[i] == 2'(gi)) begin
                        found = 1'b1;
                        win   = 2'(i);
                    end
                end
                // Output not claimed by the fast path: search from rr upward, wrapping.
                for (int k = 0; k < 4; k++) begin
                    idx = rr_q[gi] + 2'(k);
                    if (!found && settled_q[idx] && dest_q[idx] == 2'(gi)) begin
                        found  = 1'b1;
                        by_arb = 1'b1;
                        win    = idx;
                    end
                end
            end

            assign g_valid[gi] = found;
            assign g_arb[gi]   = by_arb;
            assign g_win[gi]   = win;
        end
    endgenerate

    always_comb begin
        grant = '0;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                if (g_valid[j] && g_win[j] == 2'(i)) begin
                    grant[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = ~full_q | grant;
    assign load     = in_valid & in_ready;

    always_comb begin
        full_d      = '0;
        settled_d   = '0;
        out_valid_d = g_valid;
        for (int i = 0; i < 4; i++) begin
            full_d[i]    = load[i] | (full_q[i] & ~grant[i]);
            settled_d[i] = full_q[i] & ~grant[i] & ~load[i];
            data_d[i]    = load[i] ? in_data_a[i] : data_q[i];
            dest_d[i]    = load[i] ? in_dest_a[i] : dest_q[i];
            wait_d[i]    = wait_q[i];
            if (grant[i]) begin
                wait_d[i] = '0;
            end else if (settled_q[i] && wait_q[i] != WAIT_SAT) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end
        for (int j = 0; j < 4; j++) begin
            rr_d[j]       = g_arb[j] ? g_win[j] + 2'd1 : rr_q[j];
            out_data_d[j] = g_valid[j] ? data_q[g_win[j]] : out_data_q[j];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q      <= '0;
            settled_q   <= '0;
            out_valid_q <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i]     <= '0;
                dest_q[i]     <= '0;
                wait_q[i]     <= '0;
                rr_q[i]       <= '0;
                out_data_q[i] <= '0;
            end
        end else begin
            full_q      <= full_d;
            settled_q   <= settled_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i]     <= data_d[i];
                dest_q[i]     <= dest_d[i];
                wait_q[i]     <= wait_d[i];
                rr_q[i]       <= rr_d[i];
                out_data_q[i] <= out_data_d[i];
            end
        end
    end

    always_comb begin
        stall_flag = '0;
        for (int i = 0; i < 4; i++) begin
            stall_flag[i] = (wait_q[i] == WAIT_SAT);
        end
    end

    assign dest0     = dest_q[0];
    assign dest1     = dest_q[1];
    assign dest2     = dest_q[2];
    assign dest3     = dest_q[3];
    assign out_valid = out_valid_q;
    assign out_data0 = out_data_q[0];
    assign out_data1 = out_data_q[1];
    assign out_data2 = out_data_q[2];
    assign out_data3 = out_data_q[3];

endmodule
